pi_leaf_port: RTL and testbench



---
 rtl/pi_leaf_port.sv | 165 ++++++++++++++++
 tb/tb_pi_leaf_port.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pi_leaf_port.sv
// Leaf endpoint of the BFT deflection network: injects client packets, ejects packets for POS, bounces the rest.
// bus_o is registered (bounce 1 cycle, tx->bus_o 2 cycles); optional starvation counter under PI_LEAF_STARVE_CNT_EN.

module pi_leaf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         do_push;
  logic         do_pop;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_rdy = !full;
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign do_push  = push_vld && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module pi_leaf_port #(
  parameter int PAYLOAD_W  = 32,
  parameter int ADDR_W     = 3,
  parameter int POS        = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int P_W       = 1 + ADDR_W + PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P_W-1:0]       bus_i,
  output logic [P_W-1:0]       bus_o,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [ADDR_W-1:0]    tx_addr,
  input  logic [PAYLOAD_W-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [PAYLOAD_W-1:0] rx_data,
`ifdef PI_LEAF_STARVE_CNT_EN
  output logic                 rx_src_bounce,
  output logic [15:0]          starve_cnt
`else
  output logic                 rx_src_bounce
`endif
);
  typedef struct packed {
    logic                 vld;
    logic [ADDR_W-1:0]    addr;
    logic [PAYLOAD_W-1:0] dat;
  } pkt_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [PAYLOAD_W-1:0] dat;
  } ent_t;

  localparam logic [ADDR_W-1:0] POS_A = ADDR_W'(POS);

  pkt_t arr;
  pkt_t bus_q;
  ent_t head;
  ent_t tx_ent;
  logic fifo_empty;
  logic eject_ok;
  logic do_eject;
  logic do_bounce;
  logic do_inject;
  logic bnc_q;

  assign arr    = pkt_t'(bus_i);
  assign tx_ent = '{addr: tx_addr, dat: tx_data};

  pi_leaf_fifo #(
    .W     (ADDR_W + PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (tx_valid),
    .push_rdy (tx_ready),
    .push_dat (tx_ent),
    .pop      (do_inject),
    .head_dat (head),
    .empty    (fifo_empty)
  );

  // The network never stalls, so any arrival we cannot take must go straight back up.
  assign eject_ok  = !rx_valid || rx_ready;
  assign do_eject  = arr.vld && (arr.addr == POS_A) && eject_ok;
  assign do_bounce = arr.vld && !do_eject;
  assign do_inject = !do_bounce && !fifo_empty;

  // bnc_q shadows bus_q: set while bus_o carries a packet this leaf bounced.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_q <= '0;
      bnc_q <= 1'b0;
    end else if (do_bounce) begin
      bus_q <= arr;
      bnc_q <= 1'b1;
    end else if (do_inject) begin
      bus_q <= '{vld: 1'b1, addr: head.addr, dat: head.dat};
      bnc_q <= 1'b0;
    end else begin
      bus_q <= '0;
      bnc_q <= 1'b0;
    end
  end

  assign bus_o = bus_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_src_bounce <= 1'b0;
    end else if (do_eject) begin
      rx_valid      <= 1'b1;
      rx_data       <= arr.dat;
      rx_src_bounce <= bnc_q;
    end else if (rx_ready) begin
      rx_valid      <= 1'b0;
    end
  end

`ifdef PI_LEAF_STARVE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (do_inject) begin
      starve_cnt <= '0;
    end else if (do_bounce && !fifo_empty && (starve_cnt != 16'hFFFF)) begin
      starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pi_leaf_port.sv
// Directed bench for pi_leaf_port with POS=2; checks bounce, eject, inject ordering and reset.
module tb_pi_leaf_port;
  localparam int PAYLOAD_W = 32;
  localparam int ADDR_W    = 3;
  localparam int P_W       = 1 + ADDR_W + PAYLOAD_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [P_W-1:0]       bus_i;
  logic [P_W-1:0]       bus_o;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [ADDR_W-1:0]    tx_addr;
  logic [PAYLOAD_W-1:0] tx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [PAYLOAD_W-1:0] rx_data;
  logic                 rx_src_bounce;
`ifdef PI_LEAF_STARVE_CNT_EN
  logic [15:0]          starve_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  pi_leaf_port #(
    .PAYLOAD_W  (PAYLOAD_W),
    .ADDR_W     (ADDR_W),
    .POS        (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_i         (bus_i),
    .bus_o         (bus_o),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_addr       (tx_addr),
    .tx_data       (tx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
`ifdef PI_LEAF_STARVE_CNT_EN
    .rx_src_bounce (rx_src_bounce),
    .starve_cnt    (starve_cnt)
`else
    .rx_src_bounce (rx_src_bounce)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [P_W-1:0] pk(input logic [ADDR_W-1:0] a, input logic [PAYLOAD_W-1:0] d);
    return {1'b1, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus_i    = '0;
    tx_valid = 1'b0;
    tx_addr  = '0;
    tx_data  = '0;
    rx_ready = 1'b0;
    tick();
    tick();
    chk("rst_bus_o", 64'(bus_o), 64'h0);
    chk("rst_tx_ready", 64'(tx_ready), 64'h1);
    chk("rst_rx_valid", 64'(rx_valid), 64'h0);
    chk("rst_rx_data", 64'(rx_data), 64'h0);
    chk("rst_rx_src_bounce", 64'(rx_src_bounce), 64'h0);
`ifdef PI_LEAF_STARVE_CNT_EN
    chk("rst_starve", 64'(starve_cnt), 64'h0);
`endif
    reset = 1'b0;

    // Fill the FIFO while a misrouted packet keeps bouncing, so nothing drains.
    bus_i = pk(3'd6, 32'hBB);
    for (int i = 1; i <= 4; i++) begin
      tx_valid = 1'b1;
      tx_addr  = 3'd5;
      tx_data  = 32'(i);
      tick();
      chk("fill_bounce_bus_o", 64'(bus_o), 64'(pk(3'd6, 32'hBB)));
    end
    tx_valid = 1'b0;
    chk("full_tx_ready", 64'(tx_ready), 64'h0);
`ifdef PI_LEAF_STARVE_CNT_EN
    chk("starve_3", 64'(starve_cnt), 64'h3);
`endif
    bus_i = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_bus_o", 64'(bus_o), 64'(pk(3'd5, 32'(i))));
      chk("drain_tx_ready", 64'(tx_ready), 64'h1);
`ifdef PI_LEAF_STARVE_CNT_EN
      chk("starve_clr", 64'(starve_cnt), 64'h0);
`endif
    end
    tick();
    chk("drain_void", 64'(bus_o), 64'h0);

    // Plain ejection.
    bus_i    = pk(3'd2, 32'hAA);
    rx_ready = 1'b1;
    tick();
    chk("ej_rx_valid", 64'(rx_valid), 64'h1);
    chk("ej_rx_data", 64'(rx_data), 64'hAA);
    chk("ej_bus_o", 64'(bus_o), 64'h0);
    chk("ej_src_bounce", 64'(rx_src_bounce), 64'h0);
    bus_i = '0;
    tick();
    chk("ej_consumed", 64'(rx_valid), 64'h0);

    // Bounce takes priority over a waiting FIFO packet.
    tx_valid = 1'b1;
    tx_addr  = 3'd4;
    tx_data  = 32'h44;
    tick();
    tx_valid = 1'b0;
    bus_i    = pk(3'd6, 32'hBB);
    tick();
    chk("bnc_over_inj", 64'(bus_o), 64'(pk(3'd6, 32'hBB)));
    bus_i = '0;
    tick();
    chk("inj_after_bnc", 64'(bus_o), 64'(pk(3'd4, 32'h44)));
    tick();
    chk("inj_done_void", 64'(bus_o), 64'h0);

    // Occupied ejection register: stall bounces, consume allows reload.
    bus_i    = pk(3'd2, 32'h11);
    rx_ready = 1'b0;
    tick();
    chk("hold_load", 64'(rx_data), 64'h11);
    bus_i = pk(3'd2, 32'h22);
    tick();
    chk("hold_bounce_bus_o", 64'(bus_o), 64'(pk(3'd2, 32'h22)));
    chk("hold_rx_data", 64'(rx_data), 64'h11);
    chk("hold_rx_valid", 64'(rx_valid), 64'h1);
    bus_i    = pk(3'd2, 32'h33);
    rx_ready = 1'b1;
    tick();
    chk("reload_rx_valid", 64'(rx_valid), 64'h1);
    chk("reload_rx_data", 64'(rx_data), 64'h33);
    chk("reload_src_bounce", 64'(rx_src_bounce), 64'h1);
    chk("reload_bus_o", 64'(bus_o), 64'h0);
    bus_i = '0;
    tick();
    chk("reload_consumed", 64'(rx_valid), 64'h0);

    // Mid-stream reset with a full FIFO and a held ejection.
    bus_i    = pk(3'd2, 32'h55);
    rx_ready = 1'b0;
    tick();
    bus_i = pk(3'd6, 32'hBB);
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1;
      tx_addr  = 3'd1;
      tx_data  = 32'h900 + 32'(i);
      tick();
    end
    tx_valid = 1'b0;
    chk("pre_rst_full", 64'(tx_ready), 64'h0);
    chk("pre_rst_rx_valid", 64'(rx_valid), 64'h1);
    reset = 1'b1;
    tick();
    chk("mid_rst_bus_o", 64'(bus_o), 64'h0);
    chk("mid_rst_tx_ready", 64'(tx_ready), 64'h1);
    chk("mid_rst_rx_valid", 64'(rx_valid), 64'h0);
    chk("mid_rst_rx_data", 64'(rx_data), 64'h0);
    chk("mid_rst_src_bounce", 64'(rx_src_bounce), 64'h0);
`ifdef PI_LEAF_STARVE_CNT_EN
    chk("mid_rst_starve", 64'(starve_cnt), 64'h0);
`endif
    reset = 1'b0;
    bus_i = '0;
    tick();
    tick();
    chk("post_rst_fifo_empty", 64'(bus_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
